// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running VGA raster timing generator. A clock divider produces a
// one-clk pixel strobe; horizontal/vertical counters advance on that strobe,
// and a registered decode stage turns the counters into sync, data-enable,
// pixel coordinates and a start-of-frame strobe for the downstream stages.

module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start
);

  // Raster geometry
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Terminal counts at counter width
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Decode thresholds carry one extra bit so a sync region that ends exactly
  // at the line/frame total still compares correctly.
  localparam logic [CW:0] H_ACT_X    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_START_X = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END_X   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_X    = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_START_X = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END_X   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // Asserted sync level
  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Divider width; at least one bit even when no division is needed
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Pixel strobe
  logic          div_last;
  logic          pix_tick_reg;

  // Raster counters
  logic [CW-1:0] h_cnt_reg, h_cnt_next;
  logic [CW-1:0] v_cnt_reg, v_cnt_next;
  logic          wrap_reg, wrap_next;

  // Decode stage
  logic          hsync_reg, hsync_next;
  logic          vsync_reg, vsync_next;
  logic          de_reg, de_next;
  logic [CW-1:0] x_reg, y_reg;
  logic          frame_start_reg;

  // Extended counter copies for the threshold compares
  logic [CW:0]   h_ext, v_ext;

  generate
    if (CLK_DIV > 1) begin : gen_div_count
      localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

      logic [DW-1:0] div_cnt_reg, div_cnt_next;

      // Divider next state: count 0..CLK_DIV-1 and wrap
      always_comb begin
        div_last     = (div_cnt_reg == DIV_LAST);
        div_cnt_next = div_last ? '0 : div_cnt_reg + DW'(1);
      end

      // Divider register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          div_cnt_reg <= '0;
        end else begin
          div_cnt_reg <= div_cnt_next;
        end
      end
    end else begin : gen_div_bypass
      // No division: every clk is a pixel clk
      assign div_last = 1'b1;
    end
  endgenerate

  // Registered pixel strobe, high in the clk after the divider's last count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_tick_reg <= 1'b0;
    end else begin
      pix_tick_reg <= div_last;
    end
  end

  // Counter next state: advance on the pixel strobe, wrap line then frame
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    wrap_next  = 1'b0;
    if (pix_tick_reg) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        if (v_cnt_reg == V_LAST) begin
          v_cnt_next = '0;
          wrap_next  = 1'b1;
        end else begin
          v_cnt_next = v_cnt_reg + CW'(1);
        end
      end else begin
        h_cnt_next = h_cnt_reg + CW'(1);
      end
    end
  end

  // Counter registers; wrap_reg marks the clk right after a frame wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Decode the current counters into sync and data-enable levels
  always_comb begin
    h_ext      = {1'b0, h_cnt_reg};
    v_ext      = {1'b0, v_cnt_reg};
    de_next    = (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
    hsync_next = ((h_ext >= HS_START_X) && (h_ext < HS_END_X)) ? SYNC_ON : ~SYNC_ON;
    vsync_next = ((v_ext >= VS_START_X) && (v_ext < VS_END_X)) ? SYNC_ON : ~SYNC_ON;
  end

  // Output registers: one clk behind the counters; frame_start lines up
  // with the first clk that shows (0,0) after a wrap, never the reset state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      de_reg          <= 1'b0;
      hsync_reg       <= ~SYNC_ON;
      vsync_reg       <= ~SYNC_ON;
      frame_start_reg <= 1'b0;
    end else begin
      x_reg           <= h_cnt_reg;
      y_reg           <= v_cnt_reg;
      de_reg          <= de_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      frame_start_reg <= wrap_reg;
    end
  end

  assign pix_tick    = pix_tick_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench: default 640x480 timing for reset/divider/line checks, and a
// small 15x8 raster (CLK_DIV=2, and CLK_DIV=1 with active-high sync) for the
// frame-level, mid-frame reset and parameter-override checks.

module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  logic rst_p = 1'b1;

  // Default-geometry instance
  logic       d_pix, d_hs, d_vs, d_de, d_fs;
  logic [9:0] d_x, d_y;
  // Small raster, CLK_DIV=2, active-low sync
  logic       s_pix, s_hs, s_vs, s_de, s_fs;
  logic [9:0] s_x, s_y;
  // Small raster, CLK_DIV=1, active-high sync
  logic       p_pix, p_hs, p_vs, p_de, p_fs;
  logic [9:0] p_x, p_y;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst_d), .pix_tick(d_pix), .hsync(d_hs), .vsync(d_vs),
    .de(d_de), .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .CW(10)
  ) u_s (
    .clk(clk), .rst(rst_s), .pix_tick(s_pix), .hsync(s_hs), .vsync(s_vs),
    .de(s_de), .x(s_x), .y(s_y), .frame_start(s_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1), .CW(10)
  ) u_p (
    .clk(clk), .rst(rst_p), .pix_tick(p_pix), .hsync(p_hs), .vsync(p_vs),
    .de(p_de), .x(p_x), .y(p_y), .frame_start(p_fs)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clk and sample away from the active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line / divider measurements (default instance)
  int first_tick, last_tick, ticks20, bad_gap;
  int prev_x, de_pix, hs_pix, hs_clk, hs_first, hs_last;
  int wrapped, wrap_x, wrap_y, d_fs_cnt;
  // Frame measurements (small instances)
  int c1, c2, fs_pulses, fs_high, fs_bad, de_bad, vs_bad, vs_align_bad;
  int win_de, win_vslow, win_hslow, prev_fs, prev_vs;
  int found, early_fs, x3, x4, y4, fs242;
  int ptick, pc1, pc2, p_prev_fs, win_phs, win_pvs;

  initial begin
    // ---------------- Step 1: reset and divider ----------------
    #2;
    rst_d = 1'b0;
    rst_s = 1'b0;
    rst_p = 1'b0;
    repeat (20) step();
    check("rst_hsync",       d_hs,  1);
    check("rst_vsync",       d_vs,  1);
    check("rst_de",          d_de,  0);
    check("rst_x",           d_x,   0);
    check("rst_y",           d_y,   0);
    check("rst_pix_tick",    d_pix, 0);
    check("rst_frame_start", d_fs,  0);
    check("rst_hsync_pol1",  p_hs,  0);
    check("rst_vsync_pol1",  p_vs,  0);

    // ---------------- Step 2: first line, default geometry ----------------
    first_tick = -1; last_tick = 0; ticks20 = 0; bad_gap = 0;
    prev_x = -1; de_pix = 0; hs_pix = 0; hs_clk = 0; hs_first = -1; hs_last = -1;
    wrapped = 0; wrap_x = -1; wrap_y = -1; d_fs_cnt = 0;
    #2 rst_d = 1'b1;
    for (int c = 1; c <= 3400; c++) begin
      step();
      if (d_pix) begin
        if (first_tick < 0) first_tick = c;
        else if (c - last_tick != 4) bad_gap++;
        last_tick = c;
        if (c <= 20) ticks20++;
      end
      if (d_fs) d_fs_cnt++;
      if (d_y == 0 && wrapped == 0) begin
        if (d_de && int'(d_x) != prev_x) de_pix++;
        if (!d_hs) begin
          hs_clk++;
          if (int'(d_x) != prev_x) hs_pix++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
      end
      if (prev_x == 799 && int'(d_x) != 799 && wrapped == 0) begin
        wrapped = 1;
        wrap_x  = int'(d_x);
        wrap_y  = int'(d_y);
      end
      prev_x = int'(d_x);
    end
    check("first_pix_tick_clk", first_tick, 4);
    check("pix_ticks_in_20",    ticks20,    5);
    check("pix_tick_bad_gaps",  bad_gap,    0);
    check("de_pixels_line0",    de_pix,     640);
    check("hsync_low_pixels",   hs_pix,     96);
    check("hsync_low_clks",     hs_clk,     384);
    check("hsync_first_x",      hs_first,   656);
    check("hsync_last_x",       hs_last,    751);
    check("line_wrapped",       wrapped,    1);
    check("wrap_x",             wrap_x,     0);
    check("wrap_y",             wrap_y,     1);
    check("no_fs_first_line",   d_fs_cnt,   0);

    // ---------------- Step 3: full frames, small raster ----------------
    c1 = -1; c2 = -1; fs_pulses = 0; fs_high = 0; fs_bad = 0; de_bad = 0;
    vs_bad = 0; vs_align_bad = 0; win_de = 0; win_vslow = 0; win_hslow = 0;
    prev_fs = 0; prev_vs = 1;
    #2 rst_s = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      step();
      if (s_fs) begin
        fs_high++;
        if (prev_fs == 0) begin
          fs_pulses++;
          if (c1 < 0) c1 = c;
          else if (c2 < 0) c2 = c;
          if (s_x != 0 || s_y != 0) fs_bad++;
        end
      end
      prev_fs = int'(s_fs);
      if (s_de && s_y >= 4) de_bad++;
      if (!s_vs && !(s_y == 5 || s_y == 6)) vs_bad++;
      if (int'(s_vs) != prev_vs && s_x != 0) vs_align_bad++;
      prev_vs = int'(s_vs);
      if (c1 >= 0 && c2 < 0) begin
        if (s_de) win_de++;
        if (!s_vs) win_vslow++;
        if (!s_hs) win_hslow++;
      end
    end
    check("frame_first_fs_clk",   c1,           242);
    check("frame_period",         c2 - c1,      240);
    check("frame_fs_pulses",      fs_pulses,    3);
    check("frame_fs_width_total", fs_high,      3);
    check("frame_fs_at_origin",   fs_bad,       0);
    check("de_in_vblank",         de_bad,       0);
    check("vsync_outside_lines",  vs_bad,       0);
    check("vsync_not_line_align", vs_align_bad, 0);
    check("frame_de_clks",        win_de,       64);
    check("frame_vsync_low_clks", win_vslow,    60);
    check("frame_hsync_low_clks", win_hslow,    48);

    // ---------------- Step 4: mid-frame reset ----------------
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      step();
      if (s_x == 5 && s_y == 2) found = 1;
    end
    check("midframe_point_found", found, 1);
    #2 rst_s = 1'b0;
    #1;
    check("async_rst_x",        s_x,   0);
    check("async_rst_y",        s_y,   0);
    check("async_rst_de",       s_de,  0);
    check("async_rst_hsync",    s_hs,  1);
    check("async_rst_vsync",    s_vs,  1);
    check("async_rst_pix_tick", s_pix, 0);
    check("async_rst_fs",       s_fs,  0);
    repeat (3) step();
    early_fs = 0; x3 = -1; x4 = -1; y4 = -1; fs242 = -1;
    #2 rst_s = 1'b1;
    for (int c = 1; c <= 242; c++) begin
      step();
      if (c < 242 && s_fs) early_fs++;
      if (c == 3) x3 = int'(s_x);
      if (c == 4) begin
        x4 = int'(s_x);
        y4 = int'(s_y);
      end
      if (c == 242) fs242 = int'(s_fs);
    end
    check("restart_no_early_fs", early_fs, 0);
    check("restart_x_c3",        x3,       0);
    check("restart_x_c4",        x4,       1);
    check("restart_y_c4",        y4,       0);
    check("restart_fs_c242",     fs242,    1);

    // ---------------- Step 5: CLK_DIV=1, SYNC_POL=1 ----------------
    ptick = 0; pc1 = -1; pc2 = -1; p_prev_fs = 0; win_phs = 0; win_pvs = 0;
    #2 rst_p = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (p_pix) ptick++;
      if (p_fs && p_prev_fs == 0) begin
        if (pc1 < 0) pc1 = c;
        else if (pc2 < 0) pc2 = c;
      end
      p_prev_fs = int'(p_fs);
      if (pc1 >= 0 && pc2 < 0) begin
        if (p_hs) win_phs++;
        if (p_vs) win_pvs++;
      end
    end
    check("div1_pix_tick_clks",   ptick,     300);
    check("div1_first_fs_clk",    pc1,       122);
    check("div1_frame_period",    pc2 - pc1, 120);
    check("pol1_hsync_high_clks", win_phs,   24);
    check("pol1_vsync_high_clks", win_pvs,   30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
